writeback_stage: RTL and testbench

- MEM/WB pipeline stage of the RV32IM core.
- Captures the retiring instruction bundle from EX/MEM and waits for variable-latency data-memory load responses.
- Aligns and sign/zero-extends load data, selects the writeback source, and drives the register-file write port.
- Stalls upstream stages while a load response is outstanding.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/writeback_stage_load_align.sv | 39 +++
 rtl/writeback_stage.sv | 123 ++++++++++++
 tb/tb_writeback_stage.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32IM core definitions: writeback source codes, load funct3 codes
// and the MEM/WB state type.
package riscv_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [1:0] WB_SEL_ALU  = 2'b00;
   localparam logic [1:0] WB_SEL_LOAD = 2'b01;
   localparam logic [1:0] WB_SEL_PC4  = 2'b10;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      IDLE,
      WAIT
   } wb_state_t;

endpackage

// File: rtl/writeback_stage_load_align.sv
// Load data alignment: picks the byte/halfword lane named by the low address
// bits of an aligned memory word and sign- or zero-extends it.
module load_align
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr_lo,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] value
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      byte_lane = rdata[7:0];
      case (addr_lo)
         2'd1:    byte_lane = rdata[15:8];
         2'd2:    byte_lane = rdata[23:16];
         2'd3:    byte_lane = rdata[31:24];
         default: byte_lane = rdata[7:0];
      endcase
      // Halfword lane uses only addr_lo[1]; a set addr_lo[0] is truncated here.
      half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

      value = rdata;
      case (funct3)
         F3_LB:   value = {{(XLEN-8){byte_lane[7]}}, byte_lane};
         F3_LBU:  value = {{(XLEN-8){1'b0}}, byte_lane};
         F3_LH:   value = {{(XLEN-16){half_lane[15]}}, half_lane};
         F3_LHU:  value = {{(XLEN-16){1'b0}}, half_lane};
         default: value = rdata;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB stage: retires ALU/link results directly and waits for load responses.
// Optional macro WB_MISALIGN_CHECK_EN adds misaligned-load detection (wb_misalign).
module writeback_stage
   import riscv_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ex_mem_valid,
   input  logic                  ex_mem_reg_write,
   input  logic [1:0]            ex_mem_wb_sel,
   input  logic [REG_ADDR_W-1:0] ex_mem_rd,
   input  logic [XLEN-1:0]       ex_mem_alu_result,
   input  logic [XLEN-1:0]       ex_mem_pc_plus4,
   input  logic [2:0]            ex_mem_funct3,
   input  logic                  dmem_rvalid,
   input  logic [XLEN-1:0]       dmem_rdata,
   output logic                  wb_stall,
   output logic                  mem_wb_reg_write,
   output logic [REG_ADDR_W-1:0] mem_wb_rd,
   output logic [XLEN-1:0]       mem_wb_write_data,
   output logic                  wb_retire
`ifdef WB_MISALIGN_CHECK_EN
   ,
   output logic                  wb_misalign
`endif
);

   wb_state_t             state, state_nxt;
   logic [REG_ADDR_W-1:0] stash_rd, stash_rd_nxt, rd_nxt;
   logic [2:0]            stash_funct3, stash_funct3_nxt;
   logic [1:0]            stash_addr_lo, stash_addr_lo_nxt;
   logic [XLEN-1:0]       load_value, data_nxt;
   logic                  reg_write_nxt, retire_nxt, load_ok;

   load_align #(.XLEN(XLEN)) u_load_align (
      .funct3  (stash_funct3),
      .addr_lo (stash_addr_lo),
      .rdata   (dmem_rdata),
      .value   (load_value)
   );

   assign wb_stall = (state == WAIT);

`ifdef WB_MISALIGN_CHECK_EN
   assign load_ok = !(((stash_funct3 == F3_LH || stash_funct3 == F3_LHU) && stash_addr_lo[0])
                    || (stash_funct3 == F3_LW && stash_addr_lo != 2'b00));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) wb_misalign <= 1'b0;
      else        wb_misalign <= (state == WAIT) && dmem_rvalid && !load_ok;
   end
`else
   assign load_ok = 1'b1;
`endif

   always_comb begin
      state_nxt         = state;
      reg_write_nxt     = 1'b0;
      retire_nxt        = 1'b0;
      rd_nxt            = mem_wb_rd;
      data_nxt          = mem_wb_write_data;
      stash_rd_nxt      = stash_rd;
      stash_funct3_nxt  = stash_funct3;
      stash_addr_lo_nxt = stash_addr_lo;
      case (state)
         IDLE: begin
            if (ex_mem_valid) begin
               if (ex_mem_wb_sel == WB_SEL_LOAD) begin
                  stash_rd_nxt      = ex_mem_rd;
                  stash_funct3_nxt  = ex_mem_funct3;
                  stash_addr_lo_nxt = ex_mem_alu_result[1:0];
                  state_nxt         = WAIT;
               end else begin
                  // Reserved select 2'b11 falls through to the ALU result.
                  rd_nxt        = ex_mem_rd;
                  data_nxt      = (ex_mem_wb_sel == WB_SEL_PC4) ? ex_mem_pc_plus4
                                                                : ex_mem_alu_result;
                  reg_write_nxt = ex_mem_reg_write && (ex_mem_rd != '0);
                  retire_nxt    = 1'b1;
               end
            end
         end
         WAIT: begin
            // EX/MEM is never sampled here, even on the response edge.
            if (dmem_rvalid) begin
               rd_nxt        = stash_rd;
               data_nxt      = load_value;
               reg_write_nxt = (stash_rd != '0) && load_ok;
               retire_nxt    = 1'b1;
               state_nxt     = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state             <= IDLE;
         mem_wb_reg_write  <= 1'b0;
         mem_wb_rd         <= '0;
         mem_wb_write_data <= '0;
         wb_retire         <= 1'b0;
         stash_rd          <= '0;
         stash_funct3      <= '0;
         stash_addr_lo     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state             <= state_nxt;
         mem_wb_reg_write  <= reg_write_nxt;
         mem_wb_rd         <= rd_nxt;
         mem_wb_write_data <= data_nxt;
         wb_retire         <= retire_nxt;
         stash_rd          <= stash_rd_nxt;
         stash_funct3      <= stash_funct3_nxt;
         stash_addr_lo     <= stash_addr_lo_nxt;
      end
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage; compile with +define+WB_MISALIGN_CHECK_EN
// to also exercise the misaligned-load flag.
module tb_writeback_stage;

   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic [1:0]  wb_sel;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] pc4;
      logic [2:0]  funct3;
   } bundle_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ex_mem_valid, ex_mem_reg_write;
   logic [1:0]  ex_mem_wb_sel;
   logic [4:0]  ex_mem_rd;
   logic [31:0] ex_mem_alu_result, ex_mem_pc_plus4;
   logic [2:0]  ex_mem_funct3;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        wb_stall, mem_wb_reg_write, wb_retire, mis_obs;
   logic [4:0]  mem_wb_rd;
   logic [31:0] mem_wb_write_data;

   int          total = 0;
   int          bad = 0;
   int          retire_seen = 0;
   logic [4:0]  last_rd = '0;
   logic [31:0] last_data = '0;
   logic [40:0] got, want;

   always #5 clk = ~clk;

`ifdef WB_MISALIGN_CHECK_EN
   logic wb_misalign;
   assign mis_obs = wb_misalign;
`else
   assign mis_obs = 1'b0;
`endif

   writeback_stage dut (
      .clk               (clk),
      .reset             (reset),
      .ex_mem_valid      (ex_mem_valid),
      .ex_mem_reg_write  (ex_mem_reg_write),
      .ex_mem_wb_sel     (ex_mem_wb_sel),
      .ex_mem_rd         (ex_mem_rd),
      .ex_mem_alu_result (ex_mem_alu_result),
      .ex_mem_pc_plus4   (ex_mem_pc_plus4),
      .ex_mem_funct3     (ex_mem_funct3),
      .dmem_rvalid       (dmem_rvalid),
      .dmem_rdata        (dmem_rdata),
      .wb_stall          (wb_stall),
      .mem_wb_reg_write  (mem_wb_reg_write),
      .mem_wb_rd         (mem_wb_rd),
      .mem_wb_write_data (mem_wb_write_data),
      .wb_retire         (wb_retire)
`ifdef WB_MISALIGN_CHECK_EN
      ,
      .wb_misalign       (wb_misalign)
`endif
   );

   assign got = {wb_stall, mem_wb_reg_write, mem_wb_rd, mem_wb_write_data, wb_retire, mis_obs};

   function automatic logic [40:0] pack(logic stall, logic rw, logic [4:0] rd,
                                        logic [31:0] data, logic ret, logic mis);
      return {stall, rw, rd, data, ret, mis};
   endfunction

   // Reference load value: shift the chosen lane down, mask it, then extend.
   function automatic logic [31:0] ref_load(logic [2:0] f3, int lo, logic [31:0] w);
      longint u = longint'(w);
      longint v;
      case (f3)
         3'b000, 3'b100: begin
            v = (u >> (8 * lo)) % 256;
            if (f3 == 3'b000 && v >= 128) v = v - 256;
         end
         3'b001, 3'b101: begin
            v = (u >> (16 * (lo / 2))) % 65536;
            if (f3 == 3'b001 && v >= 32768) v = v - 65536;
         end
         default: v = u;
      endcase
      return v[31:0];
   endfunction

   function automatic logic ref_misaligned(logic [2:0] f3, int lo);
      return ((f3 == 3'b001 || f3 == 3'b101) && (lo % 2 == 1)) || (f3 == 3'b010 && lo != 0);
   endfunction

   task automatic drive(input bundle_t b);
      ex_mem_valid      = b.valid;
      ex_mem_reg_write  = b.reg_write;
      ex_mem_wb_sel     = b.wb_sel;
      ex_mem_rd         = b.rd;
      ex_mem_alu_result = b.alu;
      ex_mem_pc_plus4   = b.pc4;
      ex_mem_funct3     = b.funct3;
   endtask

   function automatic bundle_t mk(logic valid, logic rw, logic [1:0] sel, logic [4:0] rd,
                                  logic [31:0] alu, logic [31:0] pc4, logic [2:0] f3);
      bundle_t b;
      b.valid = valid; b.reg_write = rw; b.wb_sel = sel; b.rd = rd;
      b.alu = alu; b.pc4 = pc4; b.funct3 = f3;
      return b;
   endfunction

   // Entered and left at a falling edge. Drives b; for a load, holds `held` on
   // EX/MEM while waiting `latency` idle cycles before answering with rdata.
   task automatic run_bundle(input bundle_t b, input bundle_t held, input int latency,
                             input logic [31:0] rdata, input string tag,
                             output int stall_cycles);
      logic [31:0] d;
      logic        m;
      int          lo;
      stall_cycles = 0;
      drive(b);
      dmem_rvalid = 1'b0;
      @(negedge clk);
      if (!b.valid) begin
         want = pack(1'b0, 1'b0, last_rd, last_data, 1'b0, 1'b0);
      end else if (b.wb_sel != 2'b01) begin
         d = (b.wb_sel == 2'b10) ? b.pc4 : b.alu;
         last_rd = b.rd;
         last_data = d;
         want = pack(1'b0, b.reg_write && (b.rd != 0), b.rd, d, 1'b1, 1'b0);
      end else begin
         drive(held);
         for (int i = 0; i <= latency; i++) begin
            if ({got[40], got[39], got[1], got[0]} !== 4'b1000) begin
               bad++;
               $display("FAIL %s_wait%0d: got stall/rw/ret/mis=%b want=1000", tag, i,
                        {got[40], got[39], got[1], got[0]});
            end
            total++;
            if (wb_stall) stall_cycles++;
            if (i == latency) begin
               dmem_rvalid = 1'b1;
               dmem_rdata  = rdata;
            end
            @(negedge clk);
         end
         dmem_rvalid = 1'b0;
         dmem_rdata  = $urandom;
         lo = int'(b.alu[1:0]);
         d  = ref_load(b.funct3, lo, rdata);
         m  = 1'b0;
`ifdef WB_MISALIGN_CHECK_EN
         m  = ref_misaligned(b.funct3, lo);
`endif
         last_rd = b.rd;
         last_data = d;
         want = pack(1'b0, (b.rd != 0) && !m, b.rd, d, 1'b1, m);
      end
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, want);
      end
      total++;
      if (wb_retire) retire_seen++;
   endtask

   bundle_t nop;
   int      sc;

   task automatic test_reset();
      nop = mk(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 3'd0);
      drive(nop);
      dmem_rvalid = 1'b0;
      dmem_rdata  = '0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      if (got !== '0) begin bad++; $display("FAIL reset_state: got=%h want=0", got); end
      total++;
      reset = 1'b1;
      @(negedge clk);
      if (got !== '0) begin bad++; $display("FAIL after_release: got=%h want=0", got); end
      total++;
   endtask

   task automatic test_reset_mid_wait();
      drive(mk(1'b1, 1'b1, 2'b01, 5'd5, 32'h0000_0100, 32'd0, 3'b010));
      @(negedge clk);
      if (wb_stall !== 1'b1) begin bad++; $display("FAIL midwait_stall: got=%b want=1", wb_stall); end
      total++;
      drive(nop);
      #2 reset = 1'b0;
      #1;
      if (got !== '0) begin bad++; $display("FAIL reset_mid_wait: got=%h want=0", got); end
      total++;
      @(negedge clk);
      reset = 1'b1;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h1111_2222;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      if (got !== '0) begin bad++; $display("FAIL stray_rvalid: got=%h want=0", got); end
      total++;
      last_rd = '0;
      last_data = '0;
   endtask

   task automatic test_alu();
      run_bundle(mk(1'b1, 1'b1, 2'b00, 5'd7, 32'h0000_1234, 32'h0, 3'd0), nop, 0, 0, "alu", sc);
      if (sc != 0) begin bad++; $display("FAIL alu_stall: got=%0d want=0", sc); end
      total++;
      run_bundle(nop, nop, 0, 0, "bubble", sc);
   endtask

   task automatic test_load_stall();
      bundle_t held;
      held = mk(1'b1, 1'b1, 2'b00, 5'd9, 32'hA5A5_0001, 32'h0, 3'd0);
      run_bundle(mk(1'b1, 1'b1, 2'b01, 5'd6, 32'h0000_2003, 32'h0, 3'b000), held, 2,
                 32'h80FF_FF00, "lb", sc);
      if (sc != 3) begin bad++; $display("FAIL lb_stall_cycles: got=%0d want=3", sc); end
      total++;
      run_bundle(held, nop, 0, 0, "held_capture", sc);
   endtask

   task automatic test_lhu_zero_latency();
      run_bundle(mk(1'b1, 1'b1, 2'b01, 5'd12, 32'h0000_0402, 32'h0, 3'b101), nop, 0,
                 32'hBEEF_0000, "lhu", sc);
      run_bundle(mk(1'b1, 1'b1, 2'b01, 5'd0, 32'h0000_0402, 32'h0, 3'b101), nop, 0,
                 32'hBEEF_0000, "lhu_rd0", sc);
   endtask

   task automatic test_back_to_back();
      bundle_t jal;
      int      r0;
      jal = mk(1'b1, 1'b1, 2'b10, 5'd1, 32'h0000_0040, 32'h0000_0104, 3'd0);
      r0 = retire_seen;
      run_bundle(mk(1'b1, 1'b1, 2'b01, 5'd3, 32'h0000_1000, 32'h0, 3'b010), jal, 1,
                 32'hDEAD_BEEF, "b2b_lw", sc);
      run_bundle(jal, nop, 0, 0, "b2b_jal", sc);
      if (retire_seen - r0 != 2) begin
         bad++;
         $display("FAIL b2b_retires: got=%0d want=2", retire_seen - r0);
      end
      total++;
   endtask

   task automatic test_random();
      bundle_t b, held;
      for (int n = 0; n < 80; n++) begin
         b.valid     = ($urandom_range(0, 4) != 0);
         b.reg_write = $urandom_range(0, 1);
         b.wb_sel    = 2'($urandom_range(0, 3));
         b.rd        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         b.alu       = $urandom;
         b.pc4       = $urandom;
         b.funct3    = 3'($urandom_range(0, 7));
         held        = mk(1'b1, 1'b1, 2'b00, 5'd31, $urandom, $urandom, 3'd0);
         run_bundle(b, held, $urandom_range(0, 3), $urandom, $sformatf("rand%0d", n), sc);
      end
   endtask

`ifdef WB_MISALIGN_CHECK_EN
   task automatic test_misalign();
      run_bundle(mk(1'b1, 1'b1, 2'b01, 5'd4, 32'h0000_0801, 32'h0, 3'b010), nop, 1,
                 32'h1234_5678, "misalign_lw", sc);
      run_bundle(nop, nop, 0, 0, "misalign_clear", sc);
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_reset_mid_wait();
      test_alu();
      test_load_stall();
      test_lhu_zero_latency();
      test_back_to_back();
`ifdef WB_MISALIGN_CHECK_EN
      test_misalign();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
